// File: rtl/mux_nx1_rr.sv
// rtl/mux_nx1_rr.sv - N-to-1 registered stream mux with per-channel hold registers
// and round-robin or fixed-priority arbitration.
module mux_nx1_rr #(
    parameter int DATA_W = 8,
    parameter int NUM_IN = 4,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    input  logic                     mode,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out,
    output logic                     out_valid,
    output logic [SEL_W-1:0]         out_sel
);

    logic [DATA_W-1:0] hold [NUM_IN];
    logic [NUM_IN-1:0] full;
    logic [NUM_IN-1:0] full_next;
    logic [NUM_IN-1:0] capture;
    logic [NUM_IN-1:0] grant_mask;
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  winner;
    logic [SEL_W-1:0]  idx;
    logic              found;
    logic              out_free;
    logic              grant;

    // Loops run backwards so the last hit written is the first in search order.
    always_comb begin
        winner   = '0;
        idx      = '0;
        found    = 1'b0;
        out_free = !out_valid || out_ready;
        if (mode) begin
            for (int i = NUM_IN - 1; i >= 0; i--) begin
                if (full[SEL_W'(i)]) begin
                    winner = SEL_W'(i);
                    found  = 1'b1;
                end
            end
        end else begin
            for (int k = NUM_IN; k >= 1; k--) begin
                idx = SEL_W'((int'(ptr) + k) % NUM_IN);
                if (full[idx]) begin
                    winner = idx;
                    found  = 1'b1;
                end
            end
        end
        grant      = out_free && found;
        grant_mask = grant ? (NUM_IN'(1) << winner) : '0;
        capture    = in_valid & in_ready;
        full_next  = (full | capture) & ~grant_mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full      <= '0;
            in_ready  <= '0;
            out       <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            ptr       <= SEL_W'(NUM_IN - 1);
            for (int i = 0; i < NUM_IN; i++) begin
                hold[i] <= '0;
            end
        end else begin
            full     <= full_next;
            in_ready <= ~full_next;
            for (int i = 0; i < NUM_IN; i++) begin
                if (capture[i]) begin
                    hold[i] <= in_data[i*DATA_W +: DATA_W];
                end
            end
            if (grant) begin
                out       <= hold[winner];
                out_sel   <= winner;
                out_valid <= 1'b1;
                ptr       <= winner;
            end else if (out_free) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nx1_rr.sv
// tb/tb_mux_nx1_rr.sv - scoreboard bench for mux_nx1_rr with directed vectors.
module tb_mux_nx1_rr;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic        out_ready;
    logic [7:0]  out;
    logic        out_valid;
    logic [1:0]  out_sel;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [9:0] sb[$];
    int pop_cyc[$];

    mux_nx1_rr #(.DATA_W(8), .NUM_IN(4)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .out_ready(out_ready), .out(out),
        .out_valid(out_valid), .out_sel(out_sel)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_extra: got sel %0d data 0x%0h expected none", out_sel, out);
            end else begin
                logic [9:0] e;
                e = sb.pop_front();
                chk("out_word", 32'({out_sel, out}), 32'(e));
            end
            pop_cyc.push_back(cyc);
        end
    end

    task automatic expect_word(input logic [1:0] sel, input logic [7:0] data);
        sb.push_back({sel, data});
    endtask

    task automatic load(input logic [3:0] mask, input logic [31:0] data);
        in_valid = mask;
        in_data  = data;
        @(posedge clk);
        #1;
        in_valid = '0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int start;
        int i0, i2, guard;
        logic [3:0] acc;
        logic [7:0] d;

        reset = 1'b1; in_data = '0; in_valid = '0; mode = 1'b0; out_ready = 1'b0;

        // Reset and release
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_out", 32'(out), 32'h00);
        chk("post_out_valid", 32'(out_valid), 32'h0);
        chk("post_out_sel", 32'(out_sel), 32'h0);
        chk("post_in_ready", 32'(in_ready), 32'hf);

        // Round-robin burst: all four channels loaded on one edge
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) expect_word(2'(k), 8'hA0 + 8'(k));
        load(4'b1111, 32'hA3A2A1A0);
        @(posedge clk);
        #1;
        chk("rr_latency_valid", 32'(out_valid), 32'h1);
        chk("rr_first_sel", 32'(out_sel), 32'h0);
        repeat (4) @(posedge clk);
        #1;
        chk("rr_end_valid", 32'(out_valid), 32'h0);
        chk("rr_hold_out", 32'(out), 32'hA3);
        chk("rr_hold_sel", 32'(out_sel), 32'h3);
        chk("rr_in_ready", 32'(in_ready), 32'hf);
        drain("rr_drain");

        // Fairness: channels 0 and 2 continuously valid
        start = pop_cyc.size();
        for (int k = 0; k < 4; k++) begin
            expect_word(2'd0, 8'h10 + 8'(k));
            expect_word(2'd2, 8'h20 + 8'(k));
        end
        i0 = 0; i2 = 0; guard = 0;
        while ((i0 < 4 || i2 < 4) && guard < 40) begin
            in_valid = {1'b0, i2 < 4, 1'b0, i0 < 4};
            in_data = '0;
            d = 8'h10 + 8'(i0); in_data[7:0] = d;
            d = 8'h20 + 8'(i2); in_data[23:16] = d;
            @(negedge clk);
            acc = in_valid & in_ready;
            @(posedge clk);
            #1;
            if (acc[0]) i0++;
            if (acc[2]) i2++;
            guard++;
        end
        in_valid = '0;
        drain("fair_drain");
        if (pop_cyc.size() >= start + 8)
            chk("fair_nogap", 32'(pop_cyc[start+7] - pop_cyc[start]), 32'd7);
        else
            chk("fair_count", 32'(pop_cyc.size() - start), 32'd8);

        // Fixed priority under a stall; ptr=2 would make round-robin pick 3 first
        mode = 1'b1;
        out_ready = 1'b0;
        expect_word(2'd2, 8'h55);
        expect_word(2'd1, 8'hC1);
        expect_word(2'd3, 8'hC3);
        load(4'b0100, 32'h00550000);
        @(posedge clk);
        #1;
        load(4'b1010, 32'hC300C100);
        for (int k = 0; k < 5; k++) begin
            chk("stall_out", 32'({out_valid, out}), 32'h155);
            chk("stall_in_ready", 32'(in_ready), 32'h5);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain("prio_drain");
        mode = 1'b0;

        // Reset mid-operation discards everything held
        out_ready = 1'b0;
        load(4'b0100, 32'h00770000);
        @(posedge clk);
        #1;
        load(4'b1111, 32'hE3E2E1E0);
        chk("full_in_ready", 32'(in_ready), 32'h0);
        chk("full_out_valid", 32'(out_valid), 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_in_ready", 32'(in_ready), 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_release_ready", 32'(in_ready), 32'hf);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) expect_word(2'(k), 8'hD0 + 8'(k));
        load(4'b1111, 32'hD3D2D1D0);
        drain("midrst_drain");

        repeat (3) @(posedge clk);
        #1;
        chk("final_idle_valid", 32'(out_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux_nx1_rr.md
MUX_NX1_RR -- requirements
Module: mux_nx1_rr

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the payload width per channel.
REQ-002 The block SHALL have parameter NUM_IN, default 4, legal range 2..16, giving the number of input channels.
REQ-003 The block SHALL have derived parameter SEL_W, equal to clog2(NUM_IN), giving the channel-index width.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in_data, input, NUM_IN*DATA_W bits: channel i at bits [i*DATA_W +: DATA_W].
REQ-007 The block SHALL have port in_valid, input, NUM_IN bits: per-channel word-present flag.
REQ-008 The block SHALL have port in_ready, output, NUM_IN bits: per-channel accept flag.
REQ-009 The block SHALL have port mode, input, 1 bit: 0 selects round-robin, 1 selects fixed priority with channel 0 highest.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accept flag.
REQ-011 The block SHALL have port out, output, DATA_W bits: selected payload, registered.
REQ-012 The block SHALL have port out_valid, output, 1 bit: out holds a valid word, registered.
REQ-013 The block SHALL have port out_sel, output, SEL_W bits: source channel of the current out word, registered.

Function
REQ-014 Each channel SHALL own a one-entry hold register with a full flag; in_ready[i] SHALL be the registered value of NOT full[i], with no combinational path from any input.
REQ-015 When in_valid[i] and in_ready[i] are both high on an edge, channel i SHALL capture in_data slice i and set full[i].
REQ-016 The output register SHALL be free on a cycle when out_valid=0, or when out_valid=1 and out_ready=1.
REQ-017 On a cycle where the output register is free and at least one full[i] is set, exactly one channel SHALL be granted.
REQ-018 On the edge ending a grant cycle, the granted word SHALL load into out, the winner index SHALL load into out_sel, out_valid SHALL be set, and full[winner] SHALL clear.
REQ-019 When the output register is free and no channel is full, out_valid SHALL clear; out and out_sel SHALL hold their last values.
REQ-020 In round-robin mode (mode=0), the search SHALL start at (ptr+1) mod NUM_IN and wrap to ptr, selecting the first full channel found.
REQ-021 In fixed-priority mode (mode=1), the lowest-index full channel SHALL win.
REQ-022 The pointer ptr (SEL_W bits) SHALL load the winner index on every grant in either mode, and SHALL be unchanged when there is no grant.
REQ-023 A change of mode SHALL take effect at the next arbitration, and no held word SHALL be dropped because of it.
REQ-024 When out_valid=1 and out_ready=0 (stall), out, out_sel, and out_valid SHALL hold, no grant SHALL occur, and hold registers SHALL keep accepting words until full.
REQ-025 Minimum latency SHALL be two edges from acceptance to out_valid: capture on edge N, out_valid on edge N+1 if the channel wins.
REQ-026 Aggregate throughput SHALL be one word per cycle; per-channel throughput SHALL be at most one word per two cycles, because in_ready is registered.
REQ-027 The same channel SHALL never be captured and granted on the same edge, since in_ready[i]=0 whenever full[i]=1.
REQ-028 Every accepted word SHALL appear on out exactly once, with no loss or duplication.

Reset
REQ-029 While reset=1 on an edge, all full flags SHALL clear, all hold registers SHALL clear to 0, out SHALL be 0, out_sel SHALL be 0, out_valid SHALL be 0, and ptr SHALL be NUM_IN-1 so that channel 0 wins first.
REQ-030 in_ready SHALL be all-zero during any cycle in which reset=1 was sampled, and SHALL become all-ones on the first edge with reset=0.
REQ-031 Reset SHALL take priority over capture and grant on the same edge, and asserting it mid-operation SHALL discard all held and output words.

Verification
REQ-032 Post-reset check (DATA_W=8, NUM_IN=4): after reset is held 2 cycles then released -> out=0x00, out_valid=0, out_sel=0, and in_ready=4'b1111 one edge later.
REQ-033 Round-robin check, mode=0, out_ready=1: channels 0..3 load 0xA0..0xA3 on the same edge -> out=A0, A1, A2, A3 on 4 consecutive cycles, out_sel=0, 1, 2, 3, then out_valid=0.
REQ-034 Fairness check, mode=0: channels 0 and 2 are continuously valid with incrementing data -> out_sel alternates 0, 2, 0, 2 with no gaps, and each channel's data sequence is in order.
REQ-035 Priority check, mode=1: with out_ready=0 and out stalled, channels 3 and 1 are both made full, then out_ready goes high -> the channel 1 word appears before the channel 3 word.
REQ-036 Backpressure check: with out=0x55, out_valid=1, and out_ready=0 for 5 cycles -> out stays 0x55, full channels show in_ready=0, and after release every word is delivered once.
REQ-037 Reset mid-operation check: assert reset with all channels full and out_valid=1 -> next edge gives out_valid=0 and in_ready=0; after release, the first grant goes to channel 0.
